// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words, writes them to IMEM and
// holds the core in reset until the image is loaded. Define BOOT_CHECKSUM_EN for the checksum word.
module imem_boot_loader #(
  parameter int unsigned       AWIDTH    = 32,
  parameter int unsigned       IWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ILoad,
  output logic [AWIDTH-1:0] IAddr,
  output logic [IWIDTH-1:0] instW,
  output logic              core_rst,
  output logic              boot_done,
  output logic              boot_err
);

  localparam int unsigned IdxW = ($clog2(MAX_WORDS + 1) > 11) ? $clog2(MAX_WORDS + 1) : 11;

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {StHdr, StLoad, StCsum, StDone, StErr} state_e;
`else
  typedef enum logic [2:0] {StHdr, StLoad, StFlush, StDone, StErr} state_e;
`endif

  state_e              r_state;
  logic [1:0]          r_lane;
  logic [IdxW-1:0]     r_idx;
  logic [IdxW-1:0]     r_count;
  logic [23:0]         r_asm;
  logic                r_rx_ready;
  logic                r_iload;
  logic [AWIDTH-1:0]   r_iaddr;
  logic [IWIDTH-1:0]   r_instw;
  logic                r_core_rst;
  logic                r_boot_done;
  logic                r_boot_err;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]         r_sum;
`endif

  logic                w_acc;
  logic [31:0]         w_word;
  logic [AWIDTH-1:0]   w_iaddr;
  logic                w_last;
  logic                w_oversize;

  // The incoming byte is the top byte of the word completed on lane 3.
  assign w_acc      = rx_valid && r_rx_ready;
  assign w_word     = {rx_data, r_asm};
  assign w_iaddr    = BASE_ADDR + AWIDTH'({r_idx, 2'b00});
  assign w_last     = (r_idx + IdxW'(1)) == r_count;
  assign w_oversize = w_word > 32'(MAX_WORDS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StHdr;
      r_lane      <= '0;
      r_idx       <= '0;
      r_count     <= '0;
      r_asm       <= '0;
      r_rx_ready  <= 1'b0;
      r_iload     <= 1'b0;
      r_iaddr     <= BASE_ADDR;
      r_instw     <= '0;
      r_core_rst  <= 1'b1;
      r_boot_done <= 1'b0;
      r_boot_err  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_iload <= 1'b0;
      case (r_state)
        StHdr: begin
          r_rx_ready <= 1'b1;
          if (w_acc) begin
            r_lane <= r_lane + 2'd1;
            r_asm  <= w_word[31:8];
            if (r_lane == 2'd3) begin
              r_count <= w_word[IdxW-1:0];
              r_idx   <= '0;
              if (w_oversize) begin
                r_state    <= StErr;
                r_rx_ready <= 1'b0;
                r_boot_err <= 1'b1;
              end else if (w_word == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
                r_state     <= StCsum;
`else
                r_state     <= StDone;
                r_rx_ready  <= 1'b0;
                r_core_rst  <= 1'b0;
                r_boot_done <= 1'b1;
`endif
              end else begin
                r_state <= StLoad;
              end
            end
          end
        end
        StLoad: begin
          if (w_acc) begin
            r_lane <= r_lane + 2'd1;
            r_asm  <= w_word[31:8];
            if (r_lane == 2'd3) begin
              r_iload <= 1'b1;
              r_iaddr <= w_iaddr;
              r_instw <= IWIDTH'(w_word);
              r_idx   <= r_idx + IdxW'(1);
`ifdef BOOT_CHECKSUM_EN
              r_sum   <= r_sum + w_word;
              if (w_last) r_state <= StCsum;
`else
              // Release the core one cycle after the final write pulse.
              if (w_last) begin
                r_state    <= StFlush;
                r_rx_ready <= 1'b0;
              end
`endif
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        StCsum: begin
          if (w_acc) begin
            r_lane <= r_lane + 2'd1;
            r_asm  <= w_word[31:8];
            if (r_lane == 2'd3) begin
              r_rx_ready <= 1'b0;
              if (w_word == r_sum) begin
                r_state     <= StDone;
                r_core_rst  <= 1'b0;
                r_boot_done <= 1'b1;
              end else begin
                r_state    <= StErr;
                r_boot_err <= 1'b1;
              end
            end
          end
        end
`else
        StFlush: begin
          r_state     <= StDone;
          r_core_rst  <= 1'b0;
          r_boot_done <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign rx_ready  = r_rx_ready;
  assign ILoad     = r_iload;
  assign IAddr     = r_iaddr;
  assign instW     = r_instw;
  assign core_rst  = r_core_rst;
  assign boot_done = r_boot_done;
  assign boot_err  = r_boot_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: image table plus hand-written reset sequences, with an
// expected-write queue checked against every ILoad pulse.
module tb_imem_boot_loader;

  localparam int unsigned MaxW = 1024;
  localparam logic [31:0] Base = 32'h0;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CsumOn = 1'b1;
  localparam int NV     = 8;
`else
  localparam bit CsumOn = 1'b0;
  localparam int NV     = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        ILoad;
  logic [31:0] IAddr;
  logic [31:0] instW;
  logic        core_rst;
  logic        boot_done;
  logic        boot_err;

  always #5 clk = ~clk;

  imem_boot_loader #(
    .AWIDTH   (32),
    .IWIDTH   (32),
    .BASE_ADDR(Base),
    .MAX_WORDS(MaxW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .ILoad    (ILoad),
    .IAddr    (IAddr),
    .instW    (instW),
    .core_rst (core_rst),
    .boot_done(boot_done),
    .boot_err (boot_err)
  );

  typedef struct packed {
    logic [31:0] hdr;
    logic        gaps;
    logic        csum_sel;
    logic [31:0] csum_val;
    logic        exp_done;
    logic        exp_err;
    logic [31:0] exp_loads;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  vec_t tbl[NV];
  wr_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cnt, load_cnt, last_acc, done_cyc, err_cyc;

  function automatic logic [31:0] word_of(input int k);
    logic [15:0] kk;
    kk = k[15:0];
    case (k)
      0:       return 32'h00500093;
      1:       return 32'h00A00113;
      2:       return 32'h12345678;
      default: return {kk ^ 16'hA5C3, kk};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (rx_valid && rx_ready) begin
      acc_cnt++;
      last_acc = cyc;
    end
    if (ILoad) begin
      load_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_iload_addr", IAddr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("iload_addr", IAddr, e.addr);
        chk("iload_data", instW, e.data);
      end
    end
    if (boot_done && done_cyc < 0) done_cyc = cyc;
    if (boot_err && err_cyc < 0) err_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        tick();
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      ok = rx_ready;
      tick();
    end
    rx_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic do_reset();
    exp_q.delete();
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick();
    tick();
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_iload", 32'(ILoad), 32'd0);
    chk("rst_iaddr", IAddr, Base);
    chk("rst_instw", instW, 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_boot_done", 32'(boot_done), 32'd0);
    chk("rst_boot_err", 32'(boot_err), 32'd0);
    acc_cnt  = 0;
    load_cnt = 0;
    last_acc = -1;
    done_cyc = -1;
    err_cyc  = -1;
    rst = 1'b1;
    tick();
    chk("ready_after_reset", 32'(rx_ready), 32'd1);
  endtask

  task automatic wait_flag();
    for (int t = 0; t < 8 && done_cyc < 0 && err_cyc < 0; t++) tick();
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    wr_t         e;
    int          n, exp_bytes, lat_exp, flag;
    logic [31:0] sum, cs, w;
    v = tbl[i];
    do_reset();
    send_word(v.hdr, v.gaps);
    n   = (v.hdr > MaxW) ? 0 : int'(v.hdr);
    sum = '0;
    for (int k = 0; k < n; k++) begin
      w      = word_of(k);
      e.addr = Base + 32'(4 * k);
      e.data = w;
      exp_q.push_back(e);
      sum += w;
      send_word(w, v.gaps);
    end
    exp_bytes = 4 + 4 * n;
    if (CsumOn && v.hdr <= MaxW) begin
      cs = v.csum_sel ? v.csum_val : sum;
      send_word(cs, v.gaps);
      exp_bytes += 4;
    end
    wait_flag();
    // Trailing bytes after the image must be ignored.
    rx_data  = 8'hFF;
    rx_valid = 1'b1;
    repeat (4) tick();
    rx_valid = 1'b0;
    chk($sformatf("v%0d_boot_done", i), 32'(boot_done), 32'(v.exp_done));
    chk($sformatf("v%0d_boot_err", i), 32'(boot_err), 32'(v.exp_err));
    chk($sformatf("v%0d_core_rst", i), 32'(core_rst), 32'(!v.exp_done));
    chk($sformatf("v%0d_rx_ready", i), 32'(rx_ready), 32'd0);
    chk($sformatf("v%0d_load_cnt", i), 32'(load_cnt), v.exp_loads);
    chk($sformatf("v%0d_pending_writes", i), 32'(exp_q.size()), 32'd0);
    chk($sformatf("v%0d_bytes_accepted", i), 32'(acc_cnt), 32'(exp_bytes));
    lat_exp = (!CsumOn && v.exp_done && n > 0) ? 2 : 1;
    flag    = v.exp_done ? done_cyc : err_cyc;
    chk($sformatf("v%0d_flag_latency", i), 32'(flag - last_acc), 32'(lat_exp));
  endtask

  initial begin
    wr_t e;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    acc_cnt  = 0;
    load_cnt = 0;
    last_acc = -1;
    done_cyc = -1;
    err_cyc  = -1;

    tbl[0] = '{hdr: 32'd2, gaps: 1'b0, csum_sel: 1'b0, csum_val: 32'h0,
               exp_done: 1'b1, exp_err: 1'b0, exp_loads: 32'd2};
    tbl[1] = '{hdr: 32'd2, gaps: 1'b1, csum_sel: 1'b0, csum_val: 32'h0,
               exp_done: 1'b1, exp_err: 1'b0, exp_loads: 32'd2};
    tbl[2] = '{hdr: MaxW + 1, gaps: 1'b0, csum_sel: 1'b0, csum_val: 32'h0,
               exp_done: 1'b0, exp_err: 1'b1, exp_loads: 32'd0};
    tbl[3] = '{hdr: 32'd0, gaps: 1'b0, csum_sel: 1'b0, csum_val: 32'h0,
               exp_done: 1'b1, exp_err: 1'b0, exp_loads: 32'd0};
    tbl[4] = '{hdr: 32'd3, gaps: 1'b1, csum_sel: 1'b0, csum_val: 32'h0,
               exp_done: 1'b1, exp_err: 1'b0, exp_loads: 32'd3};
    tbl[5] = '{hdr: MaxW, gaps: 1'b0, csum_sel: 1'b0, csum_val: 32'h0,
               exp_done: 1'b1, exp_err: 1'b0, exp_loads: MaxW};
`ifdef BOOT_CHECKSUM_EN
    tbl[6] = '{hdr: 32'd2, gaps: 1'b0, csum_sel: 1'b1, csum_val: 32'h00F001A6,
               exp_done: 1'b1, exp_err: 1'b0, exp_loads: 32'd2};
    tbl[7] = '{hdr: 32'd2, gaps: 1'b0, csum_sel: 1'b1, csum_val: 32'h00F001A7,
               exp_done: 1'b0, exp_err: 1'b1, exp_loads: 32'd2};
`endif

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset after 5 of 8 data bytes, then a fresh single-word image.
    do_reset();
    send_word(32'd2, 1'b0);
    e.addr = Base;
    e.data = word_of(0);
    exp_q.push_back(e);
    send_word(word_of(0), 1'b0);
    send_byte(8'h13, 1'b0);
    chk("midload_writes_before_reset", 32'(load_cnt), 32'd1);
    do_reset();
    send_word(32'd1, 1'b0);
    e.addr = Base;
    e.data = 32'hCAFEF00D;
    exp_q.push_back(e);
    send_word(32'hCAFEF00D, 1'b0);
    if (CsumOn) send_word(32'hCAFEF00D, 1'b0);
    wait_flag();
    chk("reload_boot_done", 32'(boot_done), 32'd1);
    chk("reload_core_rst", 32'(core_rst), 32'd0);
    chk("reload_load_cnt", 32'(load_cnt), 32'd1);
    chk("reload_pending_writes", 32'(exp_q.size()), 32'd0);

    // Reset on the same edge as a word's 4th byte cancels its write.
    do_reset();
    send_word(32'd1, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h22, 1'b0);
    rx_data  = 8'h11;
    rx_valid = 1'b1;
    rst      = 1'b0;
    tick();
    rx_valid = 1'b0;
    chk("cancel_iload", 32'(ILoad), 32'd0);
    chk("cancel_instw", instW, 32'd0);
    chk("cancel_rx_ready", 32'(rx_ready), 32'd0);
    chk("cancel_core_rst", 32'(core_rst), 32'd1);
    tick();
    chk("cancel_load_cnt", 32'(load_cnt), 32'd0);
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time program loader sitting upstream of the pipelined core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into IMEM through its load port (`ILoad`/`IAddr`/`instW`). It holds the core in reset until the image is fully written, and flags malformed or oversized images.

## Interface
Parameters:
- `AWIDTH`, 32, IMEM address width.
- `IWIDTH`, 32, instruction width; fixed at 32.
- `BASE_ADDR`, 32'h0, byte address of the first loaded word.
- `MAX_WORDS`, 1024, largest accepted image, in words.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte.
- `ILoad`  out  1  IMEM write strobe.
- `IAddr`  out  AWIDTH  IMEM write byte address.
- `instW`  out  IWIDTH  IMEM write data.
- `core_rst`  out  1  active-high reset to the core pipeline.
- `boot_done`  out  1  image loaded successfully; sticky.
- `boot_err`  out  1  image rejected; sticky.

## Operation
- A byte is accepted only on a cycle where `rx_valid && rx_ready`. Bytes with `rx_ready=0` are not consumed. The source must hold `rx_data` stable until the byte is accepted.
- Image format, all fields little-endian 32-bit:
  - header word N (word count),
  - then N data words,
  - then, if the checksum is configured in, one checksum word.
- States:
  - HDR: collect 4 header bytes.
    - N==0 goes to DONE (or CSUM when configured).
    - N>MAX_WORDS goes to ERR.
    - Otherwise goes to LOAD.
  - LOAD: collect data words.
    - When a word's 4th byte is accepted, the write for word k (k=0..N-1) is issued with `IAddr=BASE_ADDR+4*k`.
    - After word N-1, go to DONE (or CSUM).
  - CSUM: collect 4 checksum bytes, then compare. Match goes to DONE; mismatch goes to ERR.
  - DONE: `rx_ready=0`, `core_rst=0`, `boot_done=1`.
  - ERR: `rx_ready=0`, `core_rst=1`, `boot_err=1`.
- DONE and ERR are terminal; only `rst` leaves them. Any bytes offered in DONE or ERR are ignored.
- The byte lane counter (0..3) and the word index counter wrap only through state transitions. The word index is at least 11 bits wide so it covers MAX_WORDS.
- The assembled word is copied into the `instW` holding register at write issue. This frees the byte-assembly register, so `rx_ready` stays high during the `ILoad` pulse and no throughput is lost.

## Timing
- Reset values (while `rst=0`): `rx_ready=0`, `ILoad=0`, `IAddr=BASE_ADDR`, `instW=0`, `core_rst=1`, `boot_done=0`, `boot_err=0`. The state is HDR with all counters at 0.
- `rx_ready=1` on the first cycle after `rst` goes high.
- All outputs are registered.
- `ILoad` is high for exactly one cycle: the cycle after the word's 4th byte is accepted. `IAddr` and `instW` are valid in that same cycle and hold their values afterwards.
- Peak rate is 1 byte/cycle, which gives one `ILoad` pulse every 4 cycles.
- DONE entry, with the checksum compiled out:
  - N>0: `boot_done=1` and `core_rst=0` in the same cycle as the last `ILoad` pulse plus 1. This guarantees the last IMEM write completes before the core leaves reset.
  - N==0: DONE is entered on the cycle after the 4th header byte.
- With the checksum compiled in, DONE or ERR is entered on the cycle after the 4th checksum byte is accepted.
- Oversize header: ERR is entered on the cycle after the 4th header byte. No `ILoad` pulse is issued.
- Reset mid-load: `rst` low on any cycle forces the reset values on the next edge.
  - Any pending `ILoad` is cancelled.
  - Words already written stay in IMEM; they are not cleared.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - The CSUM state is included.
  - An accumulator holds the mod-2^32 sum of all N data words; the header is not included.
  - The trailing checksum word must equal this sum.
- `BOOT_CHECKSUM_EN` undefined:
  - No CSUM state and no accumulator.
  - The loader goes from the last data word straight to DONE.
  - Any bytes after the image are ignored.

## Test plan
- Nominal load (checksum off), N=2, words 0x00500093 and 0x00A00113, streamed one byte per cycle:
  - `ILoad` pulses at `IAddr` 0x0 and 0x4 with those values.
  - `boot_done=1` and `core_rst=0` one cycle after the 2nd pulse.
- Backpressure and gaps: the same image with `rx_valid` toggling randomly produces identical writes, and every byte is accepted exactly once.
- Oversize header N=MAX_WORDS+1:
  - ERR follows the header.
  - `boot_err=1`, `core_rst=1`, no `ILoad`, `rx_ready=0`.
- Checksum on, N=2, trailing word 0x00F001A6: DONE. Trailing word 0x00F001A7: `boot_err=1`.
- Zero-length image, N=0: DONE on the cycle after the header, with no `ILoad` and `core_rst=0`.
- Reset after 5 of 8 data bytes:
  - Outputs return to their reset values.
  - A fresh N=1 image then loads word 0 at `BASE_ADDR` and reaches DONE.
